// File: rtl/fetch_pkg.sv
// Shared widths and the {pc, instr} entry type for the instruction-fetch front end.
package fetch_pkg;
    localparam int ADDR_W    = 16;
    localparam int INSTR_W   = 32;
    localparam int ROM_DEPTH = 16384;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry shift FIFO of fetch entries; head and valid are held in registers.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [1:0]   occupancy_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    fetch_entry_t head_q, head_d, tail_q, tail_d;

    // Next-state: the tail shifts into the head on pop; a flush drops everything.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end else begin
                        head_d = push_data_i;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_data_i;
                    end else begin
                        tail_d = push_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign occupancy_o  = count_q;
    assign head_valid_o = valid_q;
    assign head_o       = head_q;

    fetch_skid_fifo_chk u_chk (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push_i),
        .pop_i   (pop_i),
        .count_i (count_q)
    );
endmodule

// File: rtl/fetch_skid_fifo_chk.sv
// Protocol checks for the 2-entry fetch skid FIFO: no push when full, no pop when empty.
module fetch_skid_fifo_chk (
    input logic       clk_i,
    input logic       rst_n_i,
    input logic       flush_i,
    input logic       push_i,
    input logic       pop_i,
    input logic [1:0] count_i
);
    no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !pop_i && !flush_i && (count_i == 2'd2)));

    no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(pop_i && (count_i == 2'd0)));
endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: PC and credit logic ahead of a 1-cycle-latency ROM.
// Define INSTR_FETCH_BOUNDS_CHECK_EN to stop fetch with a sticky fault at rom_addr >= ROM_DEPTH.
module instr_fetch
    import fetch_pkg::fetch_entry_t;
#(
    parameter int                ADDR_W    = fetch_pkg::ADDR_W,
    parameter int                INSTR_W   = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                ROM_DEPTH = fetch_pkg::ROM_DEPTH
) (
    input  logic               sys_clock,
    input  logic               sys_rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               fetch_fault
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              fault_q, fault_d;
    logic              deq_s, credit_s, issue_s, block_s, push_s;
    logic [2:0]        load_s, limit_s;
    logic [1:0]        occ_s;
    fetch_entry_t      push_data_s, head_s;

    // A redirect steers the ROM in the same cycle so the target costs no extra bubble.
    always_comb begin
        rom_addr = redirect_valid ? redirect_pc : pc_q;
    end

    // Credit: buffered plus in-flight words, less this cycle's pop, must leave room.
    always_comb begin
        deq_s    = instr_valid && instr_ready;
        load_s   = redirect_valid ? 3'd0 : (3'(occ_s) + 3'(inflight_q));
        limit_s  = 3'd2 + 3'(deq_s);
        credit_s = (load_s < limit_s);
    end

`ifdef INSTR_FETCH_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(ROM_DEPTH);
    logic oob_s;

    // An out-of-range fetch is refused and latches the fault until reset.
    always_comb begin
        oob_s   = ({1'b0, rom_addr} >= DEPTH_L);
        block_s = fault_q || oob_s;
        fault_d = fault_q || (fetch_en && credit_s && oob_s);
    end
`else
    logic unused_depth_s;

    // Without the check the ROM simply aliases, so ROM_DEPTH has no effect.
    always_comb begin
        unused_depth_s = (ROM_DEPTH > 0);
        block_s        = 1'b0;
        fault_d        = 1'b0;
    end
`endif

    // Issue and capture; a non-issuing cycle leaves pc at rom_addr, which covers redirects.
    always_comb begin
        issue_s           = fetch_en && credit_s && !block_s;
        push_s            = inflight_q && !redirect_valid;
        push_data_s.pc    = inflight_pc_q;
        push_data_s.instr = rom_data;
        if (issue_s) begin
            inflight_d    = 1'b1;
            inflight_pc_d = rom_addr;
            pc_d          = rom_addr + ADDR_W'(1);
        end else begin
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
            pc_d          = rom_addr;
        end
    end

    // PC, in-flight tracking and fault registers.
    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
            fault_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk_i        (sys_clock),
        .rst_n_i      (sys_rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push_s),
        .push_data_i  (push_data_s),
        .pop_i        (deq_s),
        .occupancy_o  (occ_s),
        .head_valid_o (instr_valid),
        .head_o       (head_s)
    );

    assign instr_data  = head_s.instr;
    assign instr_pc    = head_s.pc;
    assign fetch_fault = fault_q;
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch front end; the initiator/reader side of the synchronous instruction ROM.
- Issues word addresses to the ROM and absorbs the ROM's fixed 1-cycle read latency.
- Buffers returned words in a 2-entry skid FIFO and delivers {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight words.

Parameters:
- ADDR_W, 16: word-address width of PC and ROM address bus.
- INSTR_W, 32: instruction width.
- RESET_PC, 16'h0000: first word address fetched after reset.
- ROM_DEPTH, 16384: number of implemented ROM words (used only by the optional feature).

Ports:
- sys_clock  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- fetch_en  in  1  permit issuing new ROM reads.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  redirect target word address.
- rom_addr  out  ADDR_W  ROM read address; sampled by the ROM at the same rising edge.
- rom_data  in  INSTR_W  ROM read data; valid the cycle after the address is presented.
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decode accepts the head entry.
- instr_data  out  INSTR_W  instruction word of the head entry.
- instr_pc  out  ADDR_W  word address of instr_data.
- fetch_fault  out  1  sticky out-of-range fault; tied 0 without the optional feature.

Behaviour:
- Reset (sys_rst_n=0 at an edge):
  - pc_q <= RESET_PC; inflight_q <= 0; FIFO emptied; fetch_fault <= 0.
  - instr_valid=0 from the cycle after the reset edge.
  - Applies mid-operation: buffered words and any ROM response already in flight are discarded.
- rom_addr (combinational):
  - redirect_valid=1: rom_addr = redirect_pc.
  - Otherwise: rom_addr = pc_q.
- Issue condition:
  - issue = fetch_en && (occ + inflight_q - deq) < 2, where occ = FIFO occupancy (0..2) and deq = instr_valid && instr_ready.
  - On a redirect cycle, occ and inflight_q count as 0.
- On issue:
  - inflight_q <= 1 and inflight_pc_q <= rom_addr.
  - pc_q <= rom_addr + 1, with ADDR_W modulo wrap.
- No issue:
  - inflight_q <= 0.
  - pc_q holds, or <= redirect_pc if a redirect is present.
- Response capture:
  - When inflight_q=1 and no redirect this cycle, {inflight_pc_q, rom_data} is pushed into the FIFO at the edge.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Latency and throughput:
  - Address issued in cycle t -> instr_valid no earlier than cycle t+2.
  - Steady state with instr_ready=1: one instruction per cycle, contiguous PCs.
- Output:
  - instr_valid/instr_data/instr_pc come from registered FIFO head state.
  - While instr_valid=1 and instr_ready=0, all three are held stable.
- Redirect in cycle t:
  - A head handshake in cycle t still completes.
  - All other FIFO entries and the in-flight response are dropped.
  - The target is issued in cycle t if fetch_en=1; instr_valid=0 in cycle t+1; target delivered at t+2.
- fetch_en=0:
  - Nothing is issued; the in-flight response is still captured.
  - The FIFO drains normally; pc_q holds and fetching resumes at pc_q.
- Simultaneous redirect and fetch_en=0: pc_q <= redirect_pc and no issue.

Optional Feature:
- Macro: INSTR_FETCH_BOUNDS_CHECK_EN.
- Defined:
  - Issuing rom_addr >= ROM_DEPTH does not issue; instead fetch_fault <= 1 (sticky until reset).
  - While fetch_fault=1, no issue occurs; already-buffered valid words still drain.
- Undefined:
  - No check; addresses wrap at 2^ADDR_W.
  - The ROM aliases on its low index bits.
  - fetch_fault is constant 0.

Decomposition:
- Package fetch_pkg:
  - ADDR_W, INSTR_W, ROM_DEPTH constants.
  - typedef fetch_entry_t struct {pc, instr}.
- Sub-module fetch_skid_fifo:
  - 2-entry FIFO of fetch_entry_t.
  - Ports: push, flush, pop, occupancy, registered head/valid.
- instr_fetch holds the PC, the credit/issue logic and the optional bounds check.

Test Plan:
- Setup for all scenarios: ROM word i = 32'hA000_0000+i.
- Reset release, fetch_en=1, instr_ready=1 -> instr_valid first at cycle 2; instr_pc 0,1,2,... with data A0000000, A0000001, ... one per cycle.
- After 3 accepts, instr_ready=0 for 5 cycles -> instr_pc=3 / A0000003 held stable, never more than 2 buffered; on resume pc 3,4,5 with no gap or duplicate.
- redirect_valid with redirect_pc=16'h0100 while 2 words are buffered -> instr_valid=0 next cycle; then pc 0x0100, 0x0101 with data A0000100, A0000101; no stale pc delivered.
- fetch_en=0 mid-stream with instr_ready=1 -> at most 2 further words delivered, then instr_valid=0; re-enable -> next pc continues contiguously.
- sys_rst_n=0 for one cycle with instr_valid=1 -> instr_valid=0 after the reset edge; after release the first delivered pc is RESET_PC.
- Redirect to 16'h3FFF:
  - With macro: 0x3FFF delivered, then fetch_fault=1 and no further instr_valid.
  - Without macro: pc 0x4000 delivered (aliased word 0, A0000000), fetch_fault=0.
